register_file: RTL and testbench

- 32 x 64-bit RISC-V integer register file. It sits directly upstream of the ALU and supplies both of its operands.
- Source register fields are decoded straight from the 32-bit instruction word, so the ALU and register file share the same instruction bus.
- One synchronous write port is driven by writeback.
- Register x0 is hardwired to zero.

---
 rtl/register_file.sv | 51 +++++
 tb/tb_register_file.sv | 126 ++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 32 x XLEN RISC-V integer register file, two instruction-decoded read ports, one write port, one debug read port
// Ports: clk, reset (async active-high); instruction supplies rs1=[19:15] and rs2=[24:20];
//        reg_write/write_addr/write_data form the writeback port; read_data1/read_data2 feed the ALU operands;
//        dbg_addr/dbg_data form a debug read port.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-through to all read ports.
module register_file #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic            reg_write,
    input  logic [AW-1:0]   write_addr,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    logic [XLEN-1:0] regs_q [NUM_REGS-1:1];
    logic [XLEN-1:0] regs_d [NUM_REGS-1:1];
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            unused_bits;
    logic            wr_en;
    assign rs1         = instruction[19:15];
    assign rs2         = instruction[24:20];
    assign unused_bits = ^{instruction[31:25], instruction[14:0]};
    assign wr_en       = reg_write && (write_addr != '0);
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[write_addr] = write_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end
    function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        // Suppressed under reset so the outputs follow the cleared array.
        return (a == '0) ? '0 : (!reset && wr_en && write_addr == a) ? write_data : regs_q[a];
`else
        return (a == '0) ? '0 : regs_q[a];
`endif
    endfunction
    assign read_data1 = rd(rs1);
    assign read_data2 = rd(rs2);
    assign dbg_data   = rd(dbg_addr);
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file
module tb_register_file;
    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [63:0] write_data;
    logic [63:0] read_data1;
    logic [63:0] read_data2;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;
    int checks = 0;
    int errors = 0;

    register_file dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
        .read_data1(read_data1), .read_data2(read_data2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2);
        return {7'b0, r2, r1, 3'b0, 5'b0, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        reg_write  = 1'b1;
        write_addr = a;
        write_data = d;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instruction = '0; reg_write = 1'b0;
        write_addr = '0; write_data = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("reset_dbg_x%0d", i), dbg_data, 64'h0);
        end
        chk("reset_rd1", read_data1, 64'h0);
        chk("reset_rd2", read_data2, 64'h0);

        wr(5'd5, 64'h0000_0000_DEAD_BEEF);
        instruction = 32'h0002_8033;
        #1;
        chk("x5_rd1", read_data1, 64'h0000_0000_DEAD_BEEF);
        chk("x5_rd2_x0", read_data2, 64'h0);

        wr(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        dbg_addr = 5'd0;
        instruction = mk(5'd0, 5'd5);
        #1;
        chk("x0_dbg", dbg_data, 64'h0);
        chk("x0_rd1", read_data1, 64'h0);
        chk("x0_rd2_x5", read_data2, 64'h0000_0000_DEAD_BEEF);

        wr(5'd7, 64'h11);
        @(negedge clk);
        instruction = mk(5'd7, 5'd0);
        reg_write = 1'b1; write_addr = 5'd7; write_data = 64'h22;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x7_same_cycle", read_data1, 64'h22);
`else
        chk("x7_same_cycle", read_data1, 64'h11);
`endif
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        chk("x7_next_cycle", read_data1, 64'h22);

        wr(5'd31, 64'h8000_0000_0000_0001);
        dbg_addr = 5'd31;
        instruction = mk(5'd31, 5'd7);
        #1;
        chk("x31_written", dbg_data, 64'h8000_0000_0000_0001);
        #1;
        reset = 1'b1;
        #1;
        chk("x31_async_clear", dbg_data, 64'h0);
        chk("x7_async_clear", read_data2, 64'h0);
        @(negedge clk);
        reg_write = 1'b1; write_addr = 5'd31; write_data = 64'h55;
        #1;
        chk("rd1_during_reset_write", read_data1, 64'h0);
        @(posedge clk);
        #1;
        chk("x31_write_in_reset", dbg_data, 64'h0);
        @(negedge clk);
        reg_write = 1'b0;
        reset = 1'b0;
        #1;
        chk("x31_after_reset", dbg_data, 64'h0);
        dbg_addr = 5'd5;
        #1;
        chk("x5_after_reset", dbg_data, 64'h0);

        wr(5'd12, 64'h0123_4567_89AB_CDEF);
        instruction = mk(5'd12, 5'd12);
        #1;
        chk("x12_rd1", read_data1, 64'h0123_4567_89AB_CDEF);
        chk("x12_rd2", read_data2, 64'h0123_4567_89AB_CDEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
